max_pool_layer: RTL
===================

MAX_POOL_LAYER -- requirements
Module: max_pool_layer

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 8, giving the bits per channel sample (signed two's complement).
REQ-002 The block SHALL have parameter CHANNELS, default 3, giving the channels packed per pixel.
REQ-003 The block SHALL have parameter IMAGE_WIDTH, default 32, giving pixels per input row; it must be even and at least 2.
REQ-004 The block SHALL have parameter IMAGE_HEIGHT, default 32, giving rows per input frame; it must be even and at least 2.
REQ-005 Port clk: input, 1 bit, sole clock; all state changes on rising edge.
REQ-006 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-007 Port input_valid: input, 1 bit, input_data is a valid pixel this cycle.
REQ-008 Port input_data: input, D_WIDTH*CHANNELS bits, raster-order pixel from the upstream relu_layer; channel c occupies bits [c*D_WIDTH +: D_WIDTH].
REQ-009 Port output_valid: output, 1 bit, output_data holds a pooled pixel this cycle.
REQ-010 Port output_data: output, D_WIDTH*CHANNELS bits, pooled pixel, same channel packing.
REQ-011 Port frame_done: output, 1 bit, single-cycle pulse when the last pooled pixel of a frame is presented.

Function
REQ-012 The block SHALL perform 2x2 max pooling with stride 2, independently per channel, using signed comparison.
REQ-013 The block SHALL keep a column counter (0..IMAGE_WIDTH-1) and a row counter (0..IMAGE_HEIGHT-1) that advance only on cycles with input_valid=1; gaps of any length leave all state unchanged.
REQ-014 Column wrap: on an accepted pixel at column IMAGE_WIDTH-1, the column SHALL go to 0 and the row SHALL increment; at row IMAGE_HEIGHT-1 the row SHALL wrap to 0, starting a new frame with no idle cycle required.
REQ-015 The FSM SHALL have states ROW_EVEN and ROW_ODD; reset enters ROW_EVEN; each row wrap toggles the state.
REQ-016 In ROW_EVEN at an even column, the pixel SHALL be stored in a hold register.
REQ-017 In ROW_EVEN at an odd column, max(hold, pixel) SHALL be written to line-buffer entry col/2; the line buffer holds IMAGE_WIDTH/2 pixels.
REQ-018 In ROW_ODD at an even column, hold SHALL be loaded with max(line_buffer[col/2], pixel).
REQ-019 In ROW_ODD at an odd column, max(hold, pixel) SHALL be registered into output_data, and output_valid SHALL be 1 on the next cycle only; latency is 1 clock from the accepting edge.
REQ-020 output_data SHALL hold its last value while output_valid=0.
REQ-021 frame_done SHALL assert in the same cycle as output_valid for the pooled pixel from row IMAGE_HEIGHT-1, column IMAGE_WIDTH-1.
REQ-022 Each frame SHALL produce exactly (IMAGE_WIDTH/2)*(IMAGE_HEIGHT/2) pooled pixels, in raster order.
REQ-023 Back-to-back frames with input_valid held at 1 SHALL produce correct results with no corruption from line-buffer contents of the prior frame.

Reset
REQ-024 While rst_n=0, the block SHALL immediately force output_valid=0, frame_done=0, output_data=0, counters=0, hold=0 and FSM=ROW_EVEN, without waiting for clk.
REQ-025 Line-buffer contents SHALL NOT need reset; they are always written in ROW_EVEN before they are read in ROW_ODD.
REQ-026 A reset mid-frame SHALL discard the partial frame; the first valid pixel after rst_n rises SHALL be treated as row 0, column 0.

Verification (bench uses IMAGE_WIDTH=4, IMAGE_HEIGHT=4, D_WIDTH=8, CHANNELS=3)
REQ-027 Ramp: a 16-pixel frame with all channels equal to the pixel index 0..15, input_valid held at 1 -> outputs 0x050505, 0x070707, 0x0D0D0D, 0x0F0F0F; frame_done only with 0x0F0F0F.
REQ-028 Signed values: a window of channel-0 samples {0x80, 0xFF, 0x90, 0xFE} -> channel 0 output 0xFF (-1); a window with all samples 0x00 -> 0x00.
REQ-029 Per-channel independence: a window of pixels {0x010203, 0x030201, 0x020302, 0x000000} -> 0x030303.
REQ-030 Valid gaps: the ramp frame with input_valid=0 inserted for 3 cycles after every pixel -> the same 4 outputs as REQ-027, each output_valid exactly 1 cycle after its odd-row/odd-column pixel.
REQ-031 Reset mid-frame: rst_n pulsed low after pixel 9, then a full ramp frame -> no output before the new frame's pixel 5; then exactly the 4 outputs of REQ-027.
REQ-032 Back-to-back: two ramp frames, the second offset by +0x20 per channel, with no gap -> 8 outputs, the second four being 0x252525, 0x272727, 0x2D2D2D, 0x2F2F2F; frame_done pulses exactly twice.

Source files
------------

// File: rtl/max_pool_layer.sv
// 2x2 stride-2 signed max pooling over a raster pixel stream.
// One half-row line buffer carries horizontal maxima from even rows to odd rows.
module max_pool_layer #(
  parameter int D_WIDTH      = 8,
  parameter int CHANNELS     = 3,
  parameter int IMAGE_WIDTH  = 32,
  parameter int IMAGE_HEIGHT = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          input_valid,
  input  logic [D_WIDTH*CHANNELS-1:0]   input_data,
  output logic                          output_valid,
  output logic [D_WIDTH*CHANNELS-1:0]   output_data,
  output logic                          frame_done
);

  localparam int PW       = D_WIDTH * CHANNELS;
  localparam int COL_W    = $clog2(IMAGE_WIDTH);
  localparam int ROW_W    = $clog2(IMAGE_HEIGHT);
  localparam int LB_DEPTH = IMAGE_WIDTH / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef enum logic {
    ROW_EVEN,
    ROW_ODD
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [PW-1:0]     hold;
  logic [PW-1:0]     line_buf [LB_DEPTH];

  logic              col_last;
  logic              row_last;
  logic [LB_AW-1:0]  lb_idx;
  logic [PW-1:0]     max_hold_in;
  logic [PW-1:0]     max_lb_in;

  logic              hold_from_pix;
  logic              hold_from_lb;
  logic              lb_write;
  logic              emit;
  logic              emit_last;

  // Channel-wise signed maximum of two packed pixels.
  function automatic logic [PW-1:0] pix_max(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] r;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if ($signed(a[c*D_WIDTH +: D_WIDTH]) > $signed(b[c*D_WIDTH +: D_WIDTH]))
        r[c*D_WIDTH +: D_WIDTH] = a[c*D_WIDTH +: D_WIDTH];
      else
        r[c*D_WIDTH +: D_WIDTH] = b[c*D_WIDTH +: D_WIDTH];
    end
    return r;
  endfunction

  assign col_last    = (col == COL_W'(IMAGE_WIDTH - 1));
  assign row_last    = (row == ROW_W'(IMAGE_HEIGHT - 1));
  assign lb_idx      = LB_AW'(col >> 1);
  assign max_hold_in = pix_max(hold, input_data);
  assign max_lb_in   = pix_max(line_buf[lb_idx], input_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ROW_EVEN;
    end else begin
      state <= next_state;
    end
  end

  // Row parity selects the datapath action; column parity picks left/right of a window.
  always_comb begin
    next_state    = state;
    hold_from_pix = 1'b0;
    hold_from_lb  = 1'b0;
    lb_write      = 1'b0;
    emit          = 1'b0;
    emit_last     = 1'b0;
    if (input_valid) begin
      if (state == ROW_EVEN) begin
        if (!col[0]) hold_from_pix = 1'b1;
        else         lb_write      = 1'b1;
      end else begin
        if (!col[0]) begin
          hold_from_lb = 1'b1;
        end else begin
          emit      = 1'b1;
          emit_last = col_last && row_last;
        end
      end
      if (col_last) begin
        next_state = (state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col          <= '0;
      row          <= '0;
      hold         <= '0;
      output_valid <= 1'b0;
      frame_done   <= 1'b0;
      output_data  <= '0;
    end else begin
      output_valid <= emit;
      frame_done   <= emit_last;
      if (emit) begin
        output_data <= max_hold_in;
      end
      if (hold_from_pix) begin
        hold <= input_data;
      end else if (hold_from_lb) begin
        hold <= max_lb_in;
      end
      if (input_valid) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Entries are always rewritten in an even row before the odd row reads them, so no reset.
  always_ff @(posedge clk) begin
    if (lb_write) begin
      line_buf[lb_idx] <= max_hold_in;
    end
  end

endmodule
